// File: rtl/reg_file_mp.sv
// Multi-port integer register file for the decode stage: NRD combinational read
// ports, two write ports (ALU and load writeback) and a per-register load-busy scoreboard.
module reg_file_mp #(
  parameter int  XLEN   = 32,
  parameter int  NREGS  = 32,
  parameter int  NRD    = 2,
  parameter bit  BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]            regs [NREGS];
  logic [NREGS-1:0]           busy_q;
  logic [NRD-1:0][AW-1:0]     addr_arr;
  logic [NRD-1:0][XLEN-1:0]   data_arr;
  logic [NRD-1:0]             busy_arr;

  // Register 0 is only ever touched by reset, so it stays hard-wired to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every entry is reset because the architecture requires a zeroed file
      // after reset; this deliberately rules out mapping the array onto a RAM macro.
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (we1 && wa1 == AW'(r))      regs[r] <= wd1;
        else if (we0 && wa0 == AW'(r)) regs[r] <= wd0;
      end
    end
  end

  // A freshly issued load shadows a completing load to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (iss_valid && iss_rd == AW'(r))  busy_q[r] <= 1'b1;
        else if (we1 && wa1 == AW'(r))      busy_q[r] <= 1'b0;
      end
    end
  end

  assign addr_arr = rd_addr;

  always_comb begin
    // NOTE: defaults come first so every path assigns data and busy, leaving no latch.
    for (int k = 0; k < NRD; k++) begin
      data_arr[k] = regs[addr_arr[k]];
      busy_arr[k] = busy_q[addr_arr[k]];
      if (BYPASS && addr_arr[k] != '0) begin
        if (we1 && wa1 == addr_arr[k]) begin
          data_arr[k] = wd1;
          busy_arr[k] = iss_valid && (iss_rd == addr_arr[k]);
        end else if (we0 && wa0 == addr_arr[k]) begin
          data_arr[k] = wd0;
        end else if (iss_valid && iss_rd == addr_arr[k]) begin
          busy_arr[k] = 1'b1;
        end
      end
    end
  end

  assign rd_data  = data_arr;
  assign rd_busy  = busy_arr;
  assign dbg_data = regs[dbg_addr];
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: bypassing, non-bypassing and wide 4-port
// instances driven from one stimulus process and checked against array models.
module tb_reg_file_mp;

  logic        clk, rst;
  // 32x32, 2 read ports (shared by the bypass and non-bypass instances)
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic        we0, we1, iss_valid;
  logic [4:0]  wa0, wa1, iss_rd, dbg_addr;
  logic [31:0] wd0, wd1, dbg_data, nb_dbg_data, busy_vec, nb_busy_vec;
  // 16x64, 4 read ports
  logic [15:0]  w_rd_addr;
  logic [255:0] w_rd_data;
  logic [3:0]   w_rd_busy;
  logic         w_we0, w_we1, w_iss;
  logic [3:0]   w_wa0, w_wa1, w_iss_rd, w_dbg_addr;
  logic [63:0]  w_wd0, w_wd1, w_dbg_data;
  logic [15:0]  w_busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .busy_vec(busy_vec));

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .dbg_addr(dbg_addr),
    .dbg_data(nb_dbg_data), .busy_vec(nb_busy_vec));

  reg_file_mp #(.XLEN(64), .NREGS(16), .NRD(4), .BYPASS(1'b1)) u_wide (
    .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .we0(w_we0), .wa0(w_wa0), .wd0(w_wd0), .we1(w_we1), .wa1(w_wa1), .wd1(w_wd1),
    .iss_valid(w_iss), .iss_rd(w_iss_rd), .dbg_addr(w_dbg_addr),
    .dbg_data(w_dbg_data), .busy_vec(w_busy_vec));

  // Negedge at 5, posedge at 10: inputs change at posedge+1, checks run at negedge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Reference models: architectural state only
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  logic [63:0] w_reg  [16];
  bit          w_busy [16];

  typedef struct {
    string            name;
    logic [1:0][31:0] rd;
    logic [1:0]       rb;
    logic [1:0][31:0] nrd;
    logic [1:0]       nrb;
    logic [31:0]      dbg;
    logic [31:0]      bv;
    logic [3:0][63:0] wrd;
    logic [3:0]       wrb;
    logic [63:0]      wdbg;
    logic [15:0]      wbv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void clear_models();
    for (int r = 0; r < 32; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
    for (int r = 0; r < 16; r++) begin w_reg[r] = '0; w_busy[r] = 1'b0; end
  endfunction

  // What a read port must show given the current inputs and the stored state.
  function automatic void exp_n(input logic [4:0] a, input bit byp,
                                output logic [31:0] d, output bit b);
    d = m_reg[a];
    b = m_busy[a];
    if (a == 5'd0) begin
      d = '0; b = 1'b0;
    end else if (byp) begin
      if (we1 && wa1 == a) begin
        d = wd1; b = iss_valid && iss_rd == a;
      end else if (we0 && wa0 == a) begin
        d = wd0;
      end else if (iss_valid && iss_rd == a) begin
        b = 1'b1;
      end
    end
  endfunction

  function automatic void exp_w(input logic [3:0] a, output logic [63:0] d, output bit b);
    d = w_reg[a];
    b = w_busy[a];
    if (a == 4'd0) begin
      d = '0; b = 1'b0;
    end else if (w_we1 && w_wa1 == a) begin
      d = w_wd1; b = w_iss && w_iss_rd == a;
    end else if (w_we0 && w_wa0 == a) begin
      d = w_wd0;
    end else if (w_iss && w_iss_rd == a) begin
      b = 1'b1;
    end
  endfunction

  // Push the expectation for the current inputs, then apply the clock edge to the models.
  task automatic step(input string name);
    exp_t e;
    logic [31:0] d;
    logic [63:0] dw;
    bit b;
    e.name = name;
    for (int k = 0; k < 2; k++) begin
      exp_n(rd_addr[k*5 +: 5], 1'b1, d, b); e.rd[k]  = d; e.rb[k]  = b;
      exp_n(rd_addr[k*5 +: 5], 1'b0, d, b); e.nrd[k] = d; e.nrb[k] = b;
    end
    e.dbg = m_reg[dbg_addr];
    for (int r = 0; r < 32; r++) e.bv[r] = m_busy[r];
    for (int k = 0; k < 4; k++) begin
      exp_w(w_rd_addr[k*4 +: 4], dw, b); e.wrd[k] = dw; e.wrb[k] = b;
    end
    e.wdbg = w_reg[w_dbg_addr];
    for (int r = 0; r < 16; r++) e.wbv[r] = w_busy[r];
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      // Later writes overwrite earlier ones: port 1 beats port 0, issue beats clear.
      if (we0 && wa0 != 0) m_reg[wa0] = wd0;
      if (we1 && wa1 != 0) begin m_reg[wa1] = wd1; m_busy[wa1] = 1'b0; end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (w_we0 && w_wa0 != 0) w_reg[w_wa0] = w_wd0;
      if (w_we1 && w_wa1 != 0) begin w_reg[w_wa1] = w_wd1; w_busy[w_wa1] = 1'b0; end
      if (w_iss && w_iss_rd != 0) w_busy[w_iss_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_valid = 0;
    w_we0 = 0; w_we1 = 0; w_iss = 0;
  endtask

  function automatic logic [4:0] rnd_a5();
    return $urandom_range(0, 1) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] rnd_a4();
    return $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
  endfunction

  task automatic randomize_inputs();
    rd_addr   = {rnd_a5(), rnd_a5()};
    dbg_addr  = rnd_a5();
    we0 = ($urandom_range(0, 1) == 1); wa0 = rnd_a5(); wd0 = $urandom;
    we1 = ($urandom_range(0, 1) == 1); wa1 = rnd_a5(); wd1 = $urandom;
    iss_valid = ($urandom_range(0, 3) == 0); iss_rd = rnd_a5();
    w_rd_addr = {rnd_a4(), rnd_a4(), rnd_a4(), rnd_a4()};
    w_dbg_addr = rnd_a4();
    w_we0 = ($urandom_range(0, 1) == 1); w_wa0 = rnd_a4(); w_wd0 = {$urandom, $urandom};
    w_we1 = ($urandom_range(0, 1) == 1); w_wa1 = rnd_a4(); w_wd1 = {$urandom, $urandom};
    w_iss = ($urandom_range(0, 3) == 0); w_iss_rd = rnd_a4();
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        check($sformatf("%s rd_data%0d", mon_e.name, k), 64'(rd_data[k*32 +: 32]), 64'(mon_e.rd[k]));
        check($sformatf("%s rd_busy%0d", mon_e.name, k), 64'(rd_busy[k]), 64'(mon_e.rb[k]));
        check($sformatf("%s nb_rd_data%0d", mon_e.name, k), 64'(nb_rd_data[k*32 +: 32]), 64'(mon_e.nrd[k]));
        check($sformatf("%s nb_rd_busy%0d", mon_e.name, k), 64'(nb_rd_busy[k]), 64'(mon_e.nrb[k]));
      end
      check($sformatf("%s dbg_data", mon_e.name), 64'(dbg_data), 64'(mon_e.dbg));
      check($sformatf("%s nb_dbg_data", mon_e.name), 64'(nb_dbg_data), 64'(mon_e.dbg));
      check($sformatf("%s busy_vec", mon_e.name), 64'(busy_vec), 64'(mon_e.bv));
      check($sformatf("%s nb_busy_vec", mon_e.name), 64'(nb_busy_vec), 64'(mon_e.bv));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("%s w_rd_data%0d", mon_e.name, k), w_rd_data[k*64 +: 64], mon_e.wrd[k]);
        check($sformatf("%s w_rd_busy%0d", mon_e.name, k), 64'(w_rd_busy[k]), 64'(mon_e.wrb[k]));
      end
      check($sformatf("%s w_dbg_data", mon_e.name), w_dbg_data, mon_e.wdbg);
      check($sformatf("%s w_busy_vec", mon_e.name), 64'(w_busy_vec), 64'(mon_e.wbv));
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = '0; dbg_addr = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_rd = '0;
    w_rd_addr = '0; w_dbg_addr = '0; w_wa0 = '0; w_wa1 = '0; w_wd0 = '0; w_wd1 = '0; w_iss_rd = '0;
    clear_models();
    step("reset");
    rd_addr = {5'd5, 5'd9}; dbg_addr = 5'd31; w_rd_addr = 16'hF1A5; w_dbg_addr = 4'd15;
    step("reset_addr");
    rst = 1'b0;

    // Port-0 write seen same cycle with bypass, next cycle without
    we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; rd_addr = {5'd5, 5'd0}; dbg_addr = 5'd5;
    step("wr5_same");
    idle();
    step("wr5_next");

    // Both ports to reg 7: port 1 wins
    we0 = 1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1; wa1 = 5'd7; wd1 = 32'h22;
    rd_addr = {5'd7, 5'd7}; dbg_addr = 5'd7;
    step("w7_both");
    idle();
    step("w7_after");

    // Register 0 ignores writes and issues
    we0 = 1; wa0 = 5'd0; wd0 = 32'h5555_5555; we1 = 1; wa1 = 5'd0; wd1 = 32'hAAAA_AAAA;
    iss_valid = 1; iss_rd = 5'd0; rd_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
    step("wr_r0");
    idle();
    step("r0_after");

    // Load scoreboard on reg 9
    iss_valid = 1; iss_rd = 5'd9; rd_addr = {5'd9, 5'd9}; dbg_addr = 5'd9;
    step("iss9");
    idle();
    step("busy9_a");
    step("busy9_b");
    we1 = 1; wa1 = 5'd9; wd1 = 32'hCAFE;
    step("ld9");
    idle();
    step("ld9_after");

    // Issue and completion on reg 3 in the same cycle: busy stays set
    iss_valid = 1; iss_rd = 5'd3; we1 = 1; wa1 = 5'd3; wd1 = 32'h3333; rd_addr = {5'd3, 5'd3};
    step("iss_ld3");
    idle();
    step("iss_ld3_after");

    // Wide instance: distinct values in regs 1..15, alternating write ports
    for (int r = 1; r < 16; r++) begin
      w_we0 = (r % 2 == 1); w_we1 = (r % 2 == 0);
      w_wa0 = 4'(r); w_wa1 = 4'(r);
      w_wd0 = {32'(r) * 32'h0101_0101, 32'hA5A5_0000 | 32'(r)};
      w_wd1 = w_wd0;
      w_rd_addr = {4'(r), 4'(r), 4'd1, 4'd0}; w_dbg_addr = 4'(r);
      step("w_fill");
    end
    idle();
    w_rd_addr = {4'd5, 4'd5, 4'd5, 4'd5};    step("w_alias");
    w_rd_addr = {4'd15, 4'd3, 4'd2, 4'd1};   step("w_distinct");
    w_rd_addr = {4'd14, 4'd7, 4'd7, 4'd0};   step("w_mixed");

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("random");
    end

    // Asynchronous reset mid-run after random writes; sweep dbg_addr
    idle();
    rst = 1'b1;
    clear_models();
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a); rd_addr = {rnd_a5(), rnd_a5()};
      w_dbg_addr = 4'(a); w_rd_addr = {rnd_a4(), rnd_a4(), rnd_a4(), rnd_a4()};
      step("rst_sweep");
    end
    rst = 1'b0;
    we0 = 1; wa0 = 5'd4; wd0 = 32'h0BAD_F00D; rd_addr = {5'd4, 5'd4}; dbg_addr = 5'd4;
    step("post_rst_wr");
    idle();
    step("post_rst_rd");

    for (int i = 0; i < 100; i++) begin
      randomize_inputs();
      step("random2");
    end
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
